// File: rtl/rs_alu_scheduler.sv
// ALU reservation-station control: owns busy bits and an age matrix, allocates up to two free entries per cycle,
// issues the oldest ready entry with zero-cycle select; dispatch back-pressured via dp_allocatable_o, issue gated by exe_ready_i.
module rs_alu_scheduler #(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_SEL = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 dp_valid_i,
  input  logic [1:0]           dp_num_i,
  output logic                 dp_allocatable_o,
  output logic                 dp_accept_o,
  output logic [ENTRY_SEL-1:0] dp_sel_1_o,
  output logic [ENTRY_SEL-1:0] dp_sel_2_o,
  output logic [ENTRY_NUM-1:0] entry_we_o,
  output logic [ENTRY_NUM-1:0] entry_busy_o,
  input  logic [ENTRY_NUM-1:0] entry_ready_i,
  input  logic                 exe_ready_i,
  output logic                 issue_valid_o,
  output logic [ENTRY_SEL-1:0] issue_sel_o,
  output logic [ENTRY_SEL:0]   free_cnt_o,
  input  logic                 kill_i
);

  logic [ENTRY_NUM-1:0]                busy_q;
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_q;
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_d;
  logic [ENTRY_NUM-1:0]                cand;
  logic [ENTRY_NUM-1:0]                is_oldest;
  logic [ENTRY_NUM-1:0]                we;
  logic [ENTRY_NUM-1:0]                issue_clr;
  logic [ENTRY_SEL:0]                  free_cnt;
  logic [ENTRY_SEL-1:0]                sel1;
  logic [ENTRY_SEL-1:0]                sel2;
  logic [ENTRY_SEL-1:0]                isel;
  logic                                found1;
  logic                                found2;
  logic                                found_old;
  logic                                num_ok;
  logic                                alloc;
  logic                                accept;
  logic                                issue_vld;

  // Allocation looks only at registered busy, so an entry issued this cycle is not reused until next cycle.
  always_comb begin
    free_cnt = '0;
    sel1     = '0;
    sel2     = '0;
    found1   = 1'b0;
    found2   = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      free_cnt = free_cnt + {{ENTRY_SEL{1'b0}}, ~busy_q[i]};
      if (!busy_q[i]) begin
        if (!found1) begin
          sel1   = ENTRY_SEL'(i);
          found1 = 1'b1;
        end else if (!found2) begin
          sel2   = ENTRY_SEL'(i);
          found2 = 1'b1;
        end
      end
    end
  end

  assign num_ok = (dp_num_i == 2'd1) || (dp_num_i == 2'd2);
  assign alloc  = free_cnt >= {{(ENTRY_SEL-1){1'b0}}, dp_num_i};
  assign accept = dp_valid_i & alloc & num_ok & ~kill_i;

  always_comb begin
    we = '0;
    if (accept) begin
      we[sel1] = 1'b1;
      if (dp_num_i == 2'd2) we[sel2] = 1'b1;
    end
  end

  // An entry is oldest when no other candidate claims to be older than it.
  assign cand = entry_ready_i & busy_q;

  always_comb begin
    is_oldest = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < ENTRY_NUM; j++) begin
        older = older | (cand[j] & age_q[j][i]);
      end
      is_oldest[i] = cand[i] & ~older;
    end
  end

  always_comb begin
    isel      = '0;
    found_old = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (is_oldest[i] && !found_old) begin
        isel      = ENTRY_SEL'(i);
        found_old = 1'b1;
      end
    end
  end

  assign issue_vld = exe_ready_i & (|cand) & ~kill_i;

  always_comb begin
    issue_clr = '0;
    if (issue_vld) issue_clr[isel] = 1'b1;
  end

  // A written entry gets its whole row and column rewritten; busy survivors become older than it.
  always_comb begin
    age_d = age_q;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      if (we[k]) begin
        for (int j = 0; j < ENTRY_NUM; j++) begin
          if (j != k) begin
            age_d[j][k] = busy_q[j] & ~we[j];
            age_d[k][j] = 1'b0;
          end
        end
      end
    end
    if (accept && (dp_num_i == 2'd2)) begin
      age_d[sel1][sel2] = 1'b1;
      age_d[sel2][sel1] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= '0;
      age_q  <= '0;
    end else if (kill_i) begin
      busy_q <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= (busy_q & ~issue_clr) | we;
      age_q  <= age_d;
    end
  end

  assign dp_allocatable_o = alloc;
  assign dp_accept_o      = accept;
  assign dp_sel_1_o       = sel1;
  assign dp_sel_2_o       = sel2;
  assign entry_we_o       = we;
  assign entry_busy_o     = busy_q;
  assign issue_valid_o    = issue_vld;
  assign issue_sel_o      = isel;
  assign free_cnt_o       = free_cnt;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed table-driven bench for rs_alu_scheduler plus hand sequences for reset and write-to-issue latency.
module tb_rs_alu_scheduler;

  logic       clk_i;
  logic       reset_n_i;
  logic       dp_valid_i;
  logic [1:0] dp_num_i;
  logic       dp_allocatable_o;
  logic       dp_accept_o;
  logic [2:0] dp_sel_1_o;
  logic [2:0] dp_sel_2_o;
  logic [7:0] entry_we_o;
  logic [7:0] entry_busy_o;
  logic [7:0] entry_ready_i;
  logic       exe_ready_i;
  logic       issue_valid_o;
  logic [2:0] issue_sel_o;
  logic [3:0] free_cnt_o;
  logic       kill_i;

  int n_total;
  int n_pass;

  rs_alu_scheduler #(.ENTRY_NUM(8), .ENTRY_SEL(3)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .dp_valid_i       (dp_valid_i),
    .dp_num_i         (dp_num_i),
    .dp_allocatable_o (dp_allocatable_o),
    .dp_accept_o      (dp_accept_o),
    .dp_sel_1_o       (dp_sel_1_o),
    .dp_sel_2_o       (dp_sel_2_o),
    .entry_we_o       (entry_we_o),
    .entry_busy_o     (entry_busy_o),
    .entry_ready_i    (entry_ready_i),
    .exe_ready_i      (exe_ready_i),
    .issue_valid_o    (issue_valid_o),
    .issue_sel_o      (issue_sel_o),
    .free_cnt_o       (free_cnt_o),
    .kill_i           (kill_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic       dv;
    logic [1:0] dn;
    logic [7:0] rdy;
    logic       exe;
    logic       kill;
    logic [7:0] busy;
    logic [3:0] free;
    logic       alloc;
    logic       acc;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [7:0] we;
    logic       iv;
    logic [2:0] isel;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    //            dv dn rdy   exe kill busy  free al ac s1 s2 we    iv isel
    tbl[0]  = '{1, 2, 8'h00, 1, 0, 8'h00, 8, 1, 1, 0, 1, 8'h03, 0, 0};
    tbl[1]  = '{1, 1, 8'h00, 1, 0, 8'h03, 6, 1, 1, 2, 3, 8'h04, 0, 0};
    tbl[2]  = '{0, 1, 8'h01, 1, 0, 8'h07, 5, 1, 0, 3, 4, 8'h00, 1, 0};
    tbl[3]  = '{1, 1, 8'h00, 1, 0, 8'h06, 6, 1, 1, 0, 3, 8'h01, 0, 0};
    tbl[4]  = '{0, 1, 8'h07, 1, 0, 8'h07, 5, 1, 0, 3, 4, 8'h00, 1, 1};
    tbl[5]  = '{0, 1, 8'h07, 1, 0, 8'h05, 6, 1, 0, 1, 3, 8'h00, 1, 2};
    tbl[6]  = '{0, 1, 8'h07, 1, 0, 8'h01, 7, 1, 0, 1, 2, 8'h00, 1, 0};
    tbl[7]  = '{1, 2, 8'h00, 1, 0, 8'h00, 8, 1, 1, 0, 1, 8'h03, 0, 0};
    tbl[8]  = '{1, 2, 8'h00, 1, 0, 8'h03, 6, 1, 1, 2, 3, 8'h0c, 0, 0};
    tbl[9]  = '{1, 2, 8'h00, 1, 0, 8'h0f, 4, 1, 1, 4, 5, 8'h30, 0, 0};
    tbl[10] = '{1, 1, 8'h00, 1, 0, 8'h3f, 2, 1, 1, 6, 7, 8'h40, 0, 0};
    tbl[11] = '{1, 2, 8'h00, 1, 0, 8'h7f, 1, 0, 0, 7, 0, 8'h00, 0, 0};
    tbl[12] = '{1, 1, 8'h00, 1, 0, 8'h7f, 1, 1, 1, 7, 0, 8'h80, 0, 0};
    tbl[13] = '{1, 1, 8'h00, 1, 0, 8'hff, 0, 0, 0, 0, 0, 8'h00, 0, 0};
    tbl[14] = '{0, 1, 8'h70, 0, 0, 8'hff, 0, 0, 0, 0, 0, 8'h00, 0, 4};
    tbl[15] = '{0, 1, 8'h70, 1, 0, 8'hff, 0, 0, 0, 0, 0, 8'h00, 1, 4};
    tbl[16] = '{1, 1, 8'h70, 1, 0, 8'hef, 1, 1, 1, 4, 0, 8'h10, 1, 5};
    tbl[17] = '{1, 1, 8'hff, 1, 1, 8'hdf, 1, 1, 0, 5, 0, 8'h00, 0, 0};
    tbl[18] = '{0, 1, 8'hff, 1, 0, 8'h00, 8, 1, 0, 0, 1, 8'h00, 0, 0};
    tbl[19] = '{1, 3, 8'h00, 1, 0, 8'h00, 8, 1, 0, 0, 1, 8'h00, 0, 0};

    reset_n_i     = 1'b0;
    dp_valid_i    = 1'b0;
    dp_num_i      = 2'd0;
    entry_ready_i = 8'h00;
    exe_ready_i   = 1'b0;
    kill_i        = 1'b0;
    #1;
    chk("reset busy", 32'(entry_busy_o), 32'h00);
    chk("reset free_cnt", 32'(free_cnt_o), 32'd8);
    chk("reset issue_valid", 32'(issue_valid_o), 32'd0);
    chk("reset we", 32'(entry_we_o), 32'h00);
    #11;
    reset_n_i = 1'b1;

    for (int v = 0; v < 20; v++) begin
      dp_valid_i    = tbl[v].dv;
      dp_num_i      = tbl[v].dn;
      entry_ready_i = tbl[v].rdy;
      exe_ready_i   = tbl[v].exe;
      kill_i        = tbl[v].kill;
      #1;
      chk($sformatf("v%0d busy", v),        32'(entry_busy_o),     32'(tbl[v].busy));
      chk($sformatf("v%0d free_cnt", v),    32'(free_cnt_o),       32'(tbl[v].free));
      chk($sformatf("v%0d allocatable", v), 32'(dp_allocatable_o), 32'(tbl[v].alloc));
      chk($sformatf("v%0d accept", v),      32'(dp_accept_o),      32'(tbl[v].acc));
      chk($sformatf("v%0d sel1", v),        32'(dp_sel_1_o),       32'(tbl[v].s1));
      chk($sformatf("v%0d sel2", v),        32'(dp_sel_2_o),       32'(tbl[v].s2));
      chk($sformatf("v%0d we", v),          32'(entry_we_o),       32'(tbl[v].we));
      chk($sformatf("v%0d issue_valid", v), 32'(issue_valid_o),    32'(tbl[v].iv));
      chk($sformatf("v%0d issue_sel", v),   32'(issue_sel_o),      32'(tbl[v].isel));
      next_cycle();
    end
    chk("post-table busy", 32'(entry_busy_o), 32'h00);

    // Ready asserted in the write cycle must not issue until the entry is busy.
    dp_valid_i    = 1'b1;
    dp_num_i      = 2'd1;
    entry_ready_i = 8'h01;
    exe_ready_i   = 1'b1;
    kill_i        = 1'b0;
    #1;
    chk("lat write we", 32'(entry_we_o), 32'h01);
    chk("lat write issue_valid", 32'(issue_valid_o), 32'd0);
    next_cycle();
    dp_valid_i = 1'b0;
    #1;
    chk("lat next issue_valid", 32'(issue_valid_o), 32'd1);
    chk("lat next issue_sel", 32'(issue_sel_o), 32'd0);
    next_cycle();
    chk("lat after busy", 32'(entry_busy_o), 32'h00);

    // Mid-cycle asynchronous reset with busy ready entries.
    dp_valid_i    = 1'b1;
    dp_num_i      = 2'd2;
    entry_ready_i = 8'h00;
    next_cycle();
    dp_valid_i    = 1'b0;
    entry_ready_i = 8'hff;
    exe_ready_i   = 1'b1;
    #1;
    chk("pre-rst busy", 32'(entry_busy_o), 32'h03);
    chk("pre-rst issue_valid", 32'(issue_valid_o), 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("mid-rst busy", 32'(entry_busy_o), 32'h00);
    chk("mid-rst free_cnt", 32'(free_cnt_o), 32'd8);
    chk("mid-rst issue_valid", 32'(issue_valid_o), 32'd0);
    chk("mid-rst we", 32'(entry_we_o), 32'h00);
    #2;
    reset_n_i = 1'b1;
    next_cycle();
    chk("post-rst busy", 32'(entry_busy_o), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rs_alu_scheduler.md
Name: rs_alu_scheduler

Overview:
- Controls the ALU reservation station, which is an array of ENTRY_NUM ALU RS entries.
- Owns the per-entry busy bits and allocates free entries to up to two dispatched instructions per cycle.
- Generates the per-entry write enables and picks the oldest ready entry for issue to the ALU.
- Sits between dispatch and the entry array; its issue select drives the entry-output mux that feeds the ALU.

Parameters:
- ENTRY_NUM, 8, number of RS entries (power of two, ≥4).
- ENTRY_SEL, 3, log2(ENTRY_NUM), width of an entry index.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- dp_valid_i  in  1  dispatch request this cycle.
- dp_num_i  in  2  number of instructions to place (1 or 2); 0 or 3 is treated as no request.
- dp_allocatable_o  out  1  free entries ≥ dp_num_i.
- dp_accept_o  out  1  dp_valid_i & dp_allocatable_o & dp_num_i∈{1,2}.
- dp_sel_1_o  out  ENTRY_SEL  entry assigned to dispatch slot 1.
- dp_sel_2_o  out  ENTRY_SEL  entry assigned to dispatch slot 2.
- entry_we_o  out  ENTRY_NUM  one-hot/two-hot write enables (we_i of the entries).
- entry_busy_o  out  ENTRY_NUM  busy bits (busy_i of the entries).
- entry_ready_i  in  ENTRY_NUM  ready_o of each entry.
- exe_ready_i  in  1  ALU can accept an instruction this cycle.
- issue_valid_o  out  1  an entry is issued this cycle.
- issue_sel_o  out  ENTRY_SEL  index of the issued entry.
- free_cnt_o  out  ENTRY_SEL+1  number of non-busy entries.
- kill_i  in  1  flush; drop every entry.

Behaviour:
- State:
  - busy[ENTRY_NUM].
  - Age matrix age[i][j] for i≠j; 1 means entry i is older than entry j.
- Async reset (reset_n_i=0):
  - busy=0 and age=0.
  - Resulting outputs: entry_busy_o=0, free_cnt_o=ENTRY_NUM, issue_valid_o=0, entry_we_o=0.
- Allocation (combinational, from registered busy only):
  - dp_sel_1_o = lowest-index free entry.
  - dp_sel_2_o = second-lowest free entry.
  - An entry freed by issue in the current cycle is not reusable until the next cycle.
  - dp_allocatable_o = (free_cnt_o ≥ dp_num_i).
  - If dp_accept_o=0, entry_we_o=0.
  - If dp_accept_o=1, entry_we_o sets bit dp_sel_1_o, plus bit dp_sel_2_o when dp_num_i=2.
  - When no second free entry exists, dp_sel_2_o is don't-care but must be stable; drive 0.
- Issue select (combinational, 0-cycle):
  - Candidate set C = entry_ready_i & busy.
  - The oldest candidate is the i in C with no j in C where age[j][i]=1.
  - issue_valid_o = exe_ready_i & |C & ~kill_i.
  - issue_sel_o = oldest candidate index, or 0 if none.
- Next-state on posedge:
  - kill_i=1 has highest priority: busy←0, age←0; dispatch and issue are ignored (dp_accept_o forced 0, issue_valid_o forced 0).
  - Otherwise, issue clears busy[issue_sel_o].
  - Otherwise, each written entry k gets busy[k]←1; for every j with busy[j]=1 and j not being written, age[j][k]←1 and age[k][j]←0.
  - Two-slot dispatch: slot 1 is older than slot 2, so age[sel1][sel2]←1 and age[sel2][sel1]←0.
  - A written entry's age row and column are fully rewritten, so stale age bits of freed entries are never consulted; only busy entries participate.
- Simultaneous issue and dispatch are legal and independent, because allocation uses only free entries.
- A newly written entry becomes busy next cycle; its ready arrives no earlier than one cycle after the write, so the earliest issue is cycle N+1 after a dispatch in cycle N.
- free_cnt_o = popcount(~busy).
- A ready_i bit for a non-busy entry is ignored.

Test Plan:
- Reset then idle:
  - assert reset_n_i=0 mid-cycle → entry_busy_o=0 immediately, free_cnt_o=8, issue_valid_o=0.
- Dual dispatch:
  - dp_valid_i=1, dp_num_i=2 on an empty RS → dp_sel_1_o=0, dp_sel_2_o=1, entry_we_o=8'b0000_0011.
  - next cycle entry_busy_o=8'b0000_0011 and free_cnt_o=6.
- Oldest-first issue:
  - dispatch entries 0,1 in cycle 0, then entry 2 in cycle 1; free entry 0 via issue.
  - dispatch again → the new instruction lands in entry 0.
  - with entry_ready_i=8'b0000_0111 and exe_ready_i=1 → issue_sel_o=1 (oldest), then 2, then 0 on successive cycles.
- Full/back-pressure:
  - fill all 8 entries → dp_allocatable_o=0 for dp_num_i=1 and entry_we_o=0.
  - with 1 free entry and dp_num_i=2 → dp_allocatable_o=0; with dp_num_i=1 → 1.
- exe_ready_i=0 with ready entries → issue_valid_o=0 and busy unchanged; raise exe_ready_i → issue on the same cycle.
- Kill with concurrent dispatch+issue:
  - kill_i=1 alongside dp_valid_i=1 and ready entries → dp_accept_o=0, issue_valid_o=0.
  - next cycle entry_busy_o=0 and free_cnt_o=8.
